// File: rtl/warp_branch_sched_pkg.sv
// Shared types and constants for the per-warp fetch scheduler.
package warp_branch_sched_pkg;

  // Per-warp lifecycle: IDLE -> READY -> FETCHED -> (READY | BR_WAIT | IDLE)
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    READY   = 2'd1,
    FETCHED = 2'd2,
    BR_WAIT = 2'd3
  } warp_state_e;

  localparam logic [31:0] STARTUP_PC_DEFAULT = 32'h8000_0000;
  localparam logic [31:0] PC_INC             = 32'd4;

endpackage

// File: rtl/warp_branch_sched_rr_arbiter.sv
// Round-robin arbiter: searches from the pointer upward (wrapping) for the
// first requester; the pointer moves to one past the grant when adv is high.
module warp_branch_sched_rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [N-1:0]  req,
  input  logic          adv,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          grant_valid
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] cand;

  // Priority search starting at ptr; N is a power of two so the add wraps.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    cand        = '0;
    for (int i = 0; i < N; i++) begin
      cand = ptr + IW'(i);
      if (!grant_valid && req[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  // Pointer advances past the granted index only when the grant is consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (adv && grant_valid) begin
      ptr <= grant_idx + IW'(1);
    end
  end

endmodule

// File: rtl/warp_branch_sched.sv
// Per-warp fetch scheduler. Holds a PC and a small FSM per warp, issues one
// fetch per warp at a time, and parks warps on branches until the ALU
// resolves them.
//
// Fetch handshake: a request transfers on a cycle where fetch_valid and
// fetch_ready are both high. Once fetch_valid is raised, fetch_wid and
// fetch_pc stay constant and fetch_valid stays high until that transfer.
module warp_branch_sched
  import warp_branch_sched_pkg::*;
#(
  parameter int          NUM_WARPS  = 4,
  parameter int          NW_BITS    = $clog2(NUM_WARPS),
  parameter logic [31:0] STARTUP_PC = STARTUP_PC_DEFAULT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wspawn_valid,
  input  logic [NUM_WARPS-1:0]          wspawn_mask,
  input  logic [31:0]                   wspawn_pc,
  output logic                          fetch_valid,
  input  logic                          fetch_ready,
  output logic [NW_BITS-1:0]            fetch_wid,
  output logic [31:0]                   fetch_pc,
  input  logic                          dec_valid,
  input  logic [NW_BITS-1:0]            dec_wid,
  input  logic                          dec_is_br,
  input  logic                          dec_halt,
  input  logic                          br_valid,
  input  logic [NW_BITS-1:0]            br_wid,
  input  logic                          br_taken,
  input  logic [31:0]                   br_dest,
  output logic [NUM_WARPS-1:0]          active_mask,
  output logic                          proto_err,
  output logic [NUM_WARPS-1:0][1:0]     warp_state_dbg
);

  warp_state_e st     [NUM_WARPS];
  warp_state_e nxt_st [NUM_WARPS];
  logic [31:0] pc     [NUM_WARPS];
  logic [31:0] nxt_pc [NUM_WARPS];

  logic                 fire;
  logic                 select_en;
  logic                 br_ok;
  logic                 dec_ok;
  logic [NUM_WARPS-1:0] req;
  logic [NUM_WARPS-1:0] grant;
  logic [NW_BITS-1:0]   grant_idx;
  logic                 grant_valid;
  logic [31:0]          grant_pc;

  assign fire      = fetch_valid && fetch_ready;
  assign select_en = !fetch_valid || fire;
  // Events only count when the target warp is in the state that expects them.
  assign br_ok     = br_valid  && (st[br_wid]  == BR_WAIT);
  assign dec_ok    = dec_valid && (st[dec_wid] == FETCHED);

  // Request mask: READY warps, minus the one firing now (no back-to-back issue).
  always_comb begin
    req = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      req[i] = (st[i] == READY) && !(fire && (fetch_wid == NW_BITS'(i)));
    end
  end

  warp_branch_sched_rr_arbiter #(
    .N  (NUM_WARPS),
    .IW (NW_BITS)
  ) u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         (req),
    .adv         (select_en),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // One-hot PC mux for the granted warp.
  always_comb begin
    grant_pc = '0;
    for (int i = 0; i < NUM_WARPS; i++) begin
      if (grant[i]) grant_pc = grant_pc | pc[i];
    end
  end

  // Per-warp next state. Fire needs READY, br needs BR_WAIT, dec needs
  // FETCHED, spawn needs IDLE, so at most one legal event hits a warp.
  always_comb begin
    for (int i = 0; i < NUM_WARPS; i++) begin
      nxt_st[i] = st[i];
      nxt_pc[i] = pc[i];
      if (fire && (fetch_wid == NW_BITS'(i))) begin
        nxt_st[i] = FETCHED;
        nxt_pc[i] = pc[i] + PC_INC;
      end else if (br_ok && (br_wid == NW_BITS'(i))) begin
        nxt_st[i] = READY;
        if (br_taken) nxt_pc[i] = br_dest;
      end else if (dec_ok && (dec_wid == NW_BITS'(i))) begin
        if (dec_halt)       nxt_st[i] = IDLE;
        else if (dec_is_br) nxt_st[i] = BR_WAIT;
        else                nxt_st[i] = READY;
      end else if (wspawn_valid && wspawn_mask[i] && (st[i] == IDLE)) begin
        nxt_st[i] = READY;
        nxt_pc[i] = wspawn_pc;
      end
    end
  end

  // Warp state, PC and active-mask registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        st[i]          <= (i == 0) ? READY : IDLE;
        pc[i]          <= (i == 0) ? STARTUP_PC : 32'h0;
        active_mask[i] <= (i == 0);
      end
    end else begin
      for (int i = 0; i < NUM_WARPS; i++) begin
        st[i]          <= nxt_st[i];
        pc[i]          <= nxt_pc[i];
        active_mask[i] <= (nxt_st[i] != IDLE);
      end
    end
  end

  // Registered fetch request; reloaded only when empty or transferring.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_valid <= 1'b0;
      fetch_wid   <= '0;
      fetch_pc    <= '0;
    end else if (select_en) begin
      fetch_valid <= grant_valid;
      if (grant_valid) begin
        fetch_wid <= grant_idx;
        fetch_pc  <= grant_pc;
      end
    end
  end

  // Sticky flag for reports aimed at a warp in the wrong state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      proto_err <= 1'b0;
    end else if ((dec_valid && (st[dec_wid] != FETCHED)) ||
                 (br_valid  && (st[br_wid]  != BR_WAIT))) begin
      proto_err <= 1'b1;
    end
  end

  // Debug view of every warp FSM.
  always_comb begin
    for (int i = 0; i < NUM_WARPS; i++) begin
      warp_state_dbg[i] = st[i];
    end
  end

endmodule

// File: doc/warp_branch_sched.md
Name: warp_branch_sched

Overview:
- Per-warp fetch scheduler; it is the receiving end of the branch-control interface driven by the ALU unit.
- Keeps one PC and one FSM per warp, and picks ready warps round-robin to drive the fetch request.
- Allows one fetched instruction in flight per warp and waits for the decode report before fetching again.
- Parks a warp on a decoded branch until the ALU resolves it on branch_ctl, then redirects or falls through.

Parameters:
- NUM_WARPS, 4: number of warps; power of two, at least 2.
- NW_BITS, $clog2(NUM_WARPS): warp-id width.
- STARTUP_PC, 32'h8000_0000: PC loaded into warp 0 at reset.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- wspawn_valid  in  1  warp-spawn strobe.
- wspawn_mask  in  NUM_WARPS  warps to activate.
- wspawn_pc  in  32  start PC for spawned warps.
- fetch_valid  out  1  fetch request valid.
- fetch_ready  in  1  fetch stage accepts the request.
- fetch_wid  out  NW_BITS  warp id of the request.
- fetch_pc  out  32  PC to fetch.
- dec_valid  in  1  decode report for one fetched instruction.
- dec_wid  in  NW_BITS  warp id of the report.
- dec_is_br  in  1  decoded instruction is a branch/jump executed by the ALU.
- dec_halt  in  1  decoded instruction terminates the warp.
- br_valid  in  1  branch resolution valid (from branch_ctl).
- br_wid  in  NW_BITS  resolving warp.
- br_taken  in  1  branch taken.
- br_dest  in  32  taken target.
- active_mask  out  NUM_WARPS  warps not IDLE.
- proto_err  out  1  sticky protocol-error flag.

Behaviour:
- Per-warp state: pc[31:0] and an FSM with states IDLE, READY, FETCHED, BR_WAIT.
- Reset:
  - warp 0 is READY with pc = STARTUP_PC; all other warps are IDLE with pc = 0.
  - fetch_valid = 0, fetch_wid = 0, fetch_pc = 0, proto_err = 0, round-robin pointer = 0.
  - Reset mid-operation discards all in-flight state.
- Fetch output is registered:
  - When fetch_valid = 0 or the current request fires, select the next READY warp round-robin, starting at (last granted + 1) mod NUM_WARPS.
  - Drive that warp's pc and wid the following cycle.
  - While fetch_valid = 1 and fetch_ready = 0, fetch_wid and fetch_pc hold stable.
- Fire (fetch_valid && fetch_ready):
  - The warp goes FETCHED and pc <= pc + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0).
  - No new selection may pick a warp that is firing in the same cycle, so there are no back-to-back issues from one warp.
- Minimum turnaround: the decode report arrives at cycle N; the warp is READY at N+1; fetch_valid for it can assert at N+2.
- dec_valid for a warp in FETCHED:
  - dec_halt = 1: go to IDLE (halt has priority over dec_is_br).
  - else dec_is_br = 1: go to BR_WAIT.
  - else: go to READY.
- br_valid for a warp in BR_WAIT:
  - br_taken = 1: pc <= br_dest. br_taken = 0: pc unchanged; it already holds the branch PC + 4.
  - The warp goes READY.
- Protocol errors (proto_err set, stays 1 until reset; the offending event is otherwise ignored):
  - dec_valid for a warp not in FETCHED.
  - br_valid for a warp not in BR_WAIT.
- wspawn_valid: each IDLE warp in wspawn_mask goes READY with pc = wspawn_pc. Non-IDLE warps in the mask are unaffected.
- Simultaneous events:
  - dec and br events to different warps in the same cycle both apply.
  - dec and br to the same warp in the same cycle cannot both be legal; the br event is applied, and the dec event is checked against the pre-update state.
- active_mask is registered and reflects the state after each edge.
- With all warps IDLE, fetch_valid stays 0 indefinitely.

Decomposition:
- Shared package holds:
  - warp state enum: IDLE = 2'd0, READY = 2'd1, FETCHED = 2'd2, BR_WAIT = 2'd3.
  - STARTUP_PC default.
  - PC increment constant, 4.
- One sub-module, rr_arbiter: NUM_WARPS-wide request mask in; one-hot grant and encoded index out; pointer advance enable.

Test Plan:
- Reset release, no other stimulus, fetch_ready = 1 -> fetch_wid = 0, fetch_pc = 32'h8000_0000; after the dec report (non-branch), next fetch_pc = 32'h8000_0004.
- wspawn_mask = 4'b1110, wspawn_pc = 32'h100, fetch_ready = 1, dec reports returned promptly -> fetch order 0, 1, 2, 3, 0, with warps 1–3 fetching 32'h100 first, then 32'h104.
- Warp 1 fetches 32'h100, dec_is_br = 1, then br_valid with taken = 1, dest = 32'h200 -> warp 1 absent from fetch until resolution; next fetch_pc for warp 1 = 32'h200. The same sequence with taken = 0 -> 32'h104.
- fetch_ready held 0 for 5 cycles -> fetch_wid and fetch_pc stable throughout; exactly one pc + 4 after release.
- br_valid to a READY warp -> proto_err = 1 and stays 1; warp state and pc unchanged.
- dec_halt on warp 0, others IDLE -> active_mask = 0 and fetch_valid = 0; then wspawn_mask = 4'b0001, pc = 32'h40 -> fetch_pc = 32'h40.
